// File: rtl/fifo_ctrl.sv
// Pointer, flag and registered-output handshake controller for the fifo_data array.
// Array holds DEPTH entries; the prefetched output stage adds one more.
module fifo_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_BITS = 3,
  parameter int unsigned AF_LEVEL   = (1 << DEPTH_BITS) - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  flush,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   mem_count,
  output logic                  ovf_err,
  output logic                  mem_wr,
  output logic [DEPTH_BITS-1:0] mem_wptr,
  output logic [DEPTH_BITS-1:0] mem_rptr,
  input  logic [WIDTH-1:0]      mem_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_C = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AF_C    = (DEPTH_BITS+1)'(AF_LEVEL);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  out_state_e          state_q, state_d;
  logic [DEPTH_BITS:0] wp_q, wp_d;
  logic [DEPTH_BITS:0] rp_q, rp_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                ovf_q, ovf_d;
  logic [DEPTH_BITS:0] count;
  logic                load;

  // Flags decode from registered pointers only; no path from push/out_ready.
  assign count       = wp_q - rp_q;
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AF_C);
  assign empty       = (count == '0) && (state_q == OUT_EMPTY);
  assign mem_count   = count;
  assign mem_wptr    = wp_q[DEPTH_BITS-1:0];
  assign mem_rptr    = rp_q[DEPTH_BITS-1:0];
  assign mem_wr      = push & ~full & ~flush & ~rst;
  assign out_valid   = (state_q == OUT_FULL);
  assign out_data    = data_q;
  assign ovf_err     = ovf_q;
  assign load        = (count != '0) && ((state_q == OUT_EMPTY) || out_ready);

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (flush) begin
      // out_data is deliberately left holding its last value
      wp_d    = '0;
      rp_d    = '0;
      state_d = OUT_EMPTY;
    end else begin
      if (mem_wr) wp_d = wp_q + 1'b1;
      if (push && full) ovf_d = 1'b1;
      if (load) begin
        rp_d    = rp_q + 1'b1;
        data_d  = mem_dout;
        state_d = OUT_FULL;
      end else if (out_ready) begin
        state_d = OUT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer, flag and read-side handshake controller for the `fifo_data` storage array. It drives the array's write pointer, read pointer and write enable, and tracks occupancy. It prefetches the head entry into a registered output stage with a valid/ready handshake, so the array's combinational read is never exposed to downstream timing. It is instantiated beside `fifo_data` with identical `WIDTH`/`DEPTH_BITS`; `din` goes straight from the producer to the array.

## Interface
- `WIDTH`, 16, data width; must match the paired `fifo_data`.
- `DEPTH_BITS`, 3, log2 of array depth; DEPTH = 2^DEPTH_BITS.
- `AF_LEVEL`, DEPTH-2, almost_full threshold on mem_count; legal range 1..DEPTH.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `push`  in  1  producer write request; array `din` is valid this cycle.
- `flush`  in  1  synchronous discard of all queued data.
- `full`  out  1  array holds DEPTH entries; push is refused.
- `almost_full`  out  1  mem_count >= AF_LEVEL.
- `empty`  out  1  mem_count == 0 and out_valid == 0.
- `mem_count`  out  DEPTH_BITS+1  entries currently held in the array, excluding the output stage.
- `ovf_err`  out  1  sticky; push attempted while full.
- `mem_wr`  out  1  to fifo_data `wr`.
- `mem_wptr`  out  DEPTH_BITS  to fifo_data `wptr`.
- `mem_rptr`  out  DEPTH_BITS  to fifo_data `rptr`.
- `mem_dout`  in  WIDTH  from fifo_data `dout`, which is a combinational read at mem_rptr.
- `out_valid`  out  1  out_data holds the head entry.
- `out_ready`  in  1  consumer accepts out_data.
- `out_data`  out  WIDTH  registered head entry.

## Operation
- Pointers:
  - Internal wp and rp are DEPTH_BITS+1 bits wide; the MSB is a wrap bit.
  - mem_wptr and mem_rptr are the low DEPTH_BITS bits.
  - mem_count = (wp - rp) mod 2^(DEPTH_BITS+1).
  - full = (mem_count == DEPTH). Pointers wrap naturally from DEPTH-1 to 0.
- Write:
  - mem_wr = push & ~full & ~flush & ~rst (combinational).
  - When mem_wr is high, wp increments at the clock edge, on the same edge the array stores din.
  - push & full & ~flush sets ovf_err; the data is dropped and wp is unchanged.
- Output stage, two states:
  - OUT_EMPTY (out_valid=0) and OUT_FULL (out_valid=1).
  - load = (mem_count != 0) & (~out_valid | out_ready).
  - On load: out_data <= mem_dout, rp++, state goes to OUT_FULL.
  - In OUT_FULL, out_ready & ~load → OUT_EMPTY; out_data holds its value.
  - In OUT_FULL, out_ready & load → stays in OUT_FULL with the next entry (back-to-back, one entry per cycle).
  - In OUT_FULL, ~out_ready → out_data and out_valid are held stable.
- Total capacity is DEPTH+1 entries (array plus output stage).
- Simultaneous push and load while full: push is still refused, because full comes from registered pointers. There is no write-through.
- Simultaneous push and load otherwise: both happen; mem_count is unchanged.
- flush:
  - Next edge: wp = rp = 0, out_valid = 0.
  - Any push in the same cycle is discarded, and ovf_err is not set.
  - out_data is not cleared.
  - ovf_err is cleared only by rst.
- rst has priority over flush; rst mid-transfer abandons all data.

## Timing
- Reset values:
  - wp = rp = 0, mem_wptr = mem_rptr = 0, mem_count = 0.
  - full = 0, almost_full = 0, empty = 1, ovf_err = 0.
  - out_valid = 0, out_data = 0.
  - mem_wr = 0 while rst is high.
- full, almost_full, empty and mem_count are decoded from registers only; they have no combinational path from push or out_ready.
- mem_wr has a combinational path from push only.
- Latency: push in cycle N into an empty controller gives mem_count=1 in N+1 and out_valid=1 with the data in N+2.
- Throughput: one push and one pop per cycle are sustained indefinitely.

## Test plan
DEPTH_BITS=3, WIDTH=16, AF_LEVEL=6.
- Reset, then idle 3 cycles: empty=1, out_valid=0, mem_count=0, mem_wr=0, out_data=0.
- Push 0x0001 in cycle 0 with out_ready=1: out_valid=1 and out_data=0x0001 in cycle 2; empty=1 in cycle 3.
- out_ready=0, push 0x0010..0x0018 (9 words), then push 0x0019:
  - almost_full rises when mem_count=6; full=1 after the 9th push.
  - 0x0019 is refused with mem_wr=0, and ovf_err=1 and stays 1.
- From full, out_ready=1 while pushing continuously:
  - out_data sequence is 0x0010..0x0018 in order with no bubbles.
  - Pointers wrap 7→0 with correct data.
- 4 entries queued, out_valid=1, assert flush together with push: next cycle mem_count=0, out_valid=0, empty=1, the pushed word never appears, and ovf_err is unchanged.
- Assert rst mid-stream with push=1 and out_ready=1: all outputs return to the reset values on the next cycle.
